// File: rtl/mtm_alu_frame_rx.sv
// rtl/mtm_alu_frame_rx.sv - serial packet receiver assembling {A, B, op} records with CRC/count/opcode checks
module mtm_alu_frame_rx #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_op,
  output logic [2:0]        out_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int N  = DATA_W / 8;
  localparam int CW = $clog2(2 * N + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(2 * N);
  localparam logic [CW-1:0] CNT_MAX  = CW'(2 * N + 1);

  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_FLAG, S_PAYLOAD, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  flag_q, flag_d;
  logic [7:0]            byte_q, byte_d;
  logic [2*DATA_W-1:0]   sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_a_q, out_a_d;
  logic [DATA_W-1:0]     out_b_q, out_b_d;
  logic [2:0]            out_op_q, out_op_d;
  logic [2:0]            out_err_q, out_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  logic [3:0]            crc_calc;
  logic [2:0]            cmd_op;
  logic                  op_ok;
  logic [2:0]            cmd_err;

  // Bit string is {B, A, 1, op}; sr_q already holds B in its upper half.
  function automatic logic [3:0] crc4(input logic [2*DATA_W+3:0] bits);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 2*DATA_W+3; i >= 0; i--) begin
      fb = c[3] ^ bits[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  always_comb begin
    cmd_op   = byte_q[6:4];
    crc_calc = crc4({sr_q, 1'b1, cmd_op});
    op_ok    = (cmd_op == 3'b000) || (cmd_op == 3'b001) ||
               (cmd_op == 3'b100) || (cmd_op == 3'b101);
    if (cnt_q != CNT_FULL)
      cmd_err = ERR_DATA;
    else if (crc_calc != byte_q[3:0])
      cmd_err = ERR_CRC;
    else if (!op_ok)
      cmd_err = ERR_OP;
    else
      cmd_err = 3'b000;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    flag_d      = flag_q;
    byte_d      = byte_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_op_d    = out_op_q;
    out_err_d   = out_err_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!sin)
          state_d = S_FLAG;
      end
      S_FLAG: begin
        flag_d    = sin;
        bit_cnt_d = 3'd7;
        state_d   = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        byte_d    = {byte_q[6:0], sin};
        bit_cnt_d = bit_cnt_q - 3'd1;
        if (bit_cnt_q == 3'd0)
          state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (!sin) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          sr_d        = '0;
        end else if (!flag_q) begin
          sr_d = {sr_q[2*DATA_W-9:0], byte_q};
          if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          // A record leaving this same cycle frees the slot for the new one.
          if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_b_d     = sr_q[2*DATA_W-1:DATA_W];
            out_a_d     = sr_q[DATA_W-1:0];
            out_op_d    = cmd_op;
            out_err_d   = cmd_err;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      flag_q      <= 1'b0;
      byte_q      <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_op_q    <= '0;
      out_err_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      flag_q      <= flag_d;
      byte_q      <= byte_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_op_q    <= out_op_d;
      out_err_q   <= out_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_op    = out_op_q;
  assign out_err   = out_err_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/mtm_alu_frame_rx.md
# mtm_alu_frame_rx

Parametrised serial frame receiver for the ALU datapath, the next generation of the fixed 32-bit deserializer. It decodes the 11-bit serial packet stream on `sin`, assembles two DATA_W-bit operands plus the command byte, and checks frame count, CRC and opcode. It presents one complete record per command frame to the core through a valid/ready handshake. It sits between the `sin` pin and the ALU core, in place of the fixed deserializer.

## Interface
- DATA_W, 32, operand width in bits; a multiple of 8 in the range 8..64; N = DATA_W/8 data frames per operand
- clk  input  1  posedge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- sin  input  1  serial input, idle high, one bit per clock
- out_valid  output  1  record available
- out_ready  input  1  consumer accepts the record
- out_a  output  DATA_W  operand A
- out_b  output  DATA_W  operand B
- out_op  output  3  opcode
- out_err  output  3  one-hot {ERR_DATA, ERR_CRC, ERR_OP}; 000 means a valid command
- frame_err  output  1  one-cycle pulse when a bad stop bit is seen
- overrun  output  1  one-cycle pulse when a record is dropped

## Operation
- Packet format: start bit 0, flag bit (0 = DATA, 1 = CMD), 8 payload bits MSB first, stop bit 1. The packet is 11 bits and takes 11 clocks.
- Receive FSM:
  - IDLE: leave on sin=0.
  - FLAG: sample the flag bit.
  - PAYLOAD: 8 clocks, bit counter 7..0.
  - STOP: sample the stop bit, then return to IDLE.
- Stop bit = 0: discard the packet, clear the data-frame counter and the operand shift registers, and pulse frame_err. No record is produced.
- DATA packets: shift the payload into a 2·DATA_W shift register. The first N bytes form B (MSB byte first) and the next N bytes form A. The data-frame counter saturates at 2N+1.
- CMD packet payload: bit7 = 0, bits[6:4] = op, bits[3:0] = crc.
- The data-frame counter is cleared after every CMD packet and after every framing error.
- Error priority on a CMD packet:
  - Data-frame count ≠ 2N → ERR_DATA.
  - Otherwise, computed CRC ≠ crc → ERR_CRC.
  - Otherwise, op not in {000 AND, 001 OR, 100 ADD, 101 SUB} → ERR_OP.
  - Exactly one error bit is set, or none.
- CRC definition:
  - CRC-4, polynomial x^4+x+1, initial value 0000.
  - Input is the bit string {B, A, 1'b1, op}, MSB first, 2·DATA_W+4 bits.
  - Per-bit step: fb = crc[3]^bit; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
- Record contents:
  - out_a, out_b and out_op always carry the assembled values.
  - Under ERR_DATA, out_a and out_b are don't-care.
- Output register is one entry deep:
  - It loads when the CMD stop bit is 1 and the register is empty, or when out_ready=1 in that same cycle.
  - Otherwise the new record is dropped, overrun pulses, and the held record is unchanged.
- Handshake:
  - Transfer happens on clk when out_valid && out_ready.
  - out_* must stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, out_a=0, out_b=0, out_op=0, out_err=000, frame_err=0, overrun=0. FSM goes to IDLE; counters and CRC clear.
- Reset mid-packet or mid-record discards everything. Reception restarts at the next falling edge of sin after rst_n rises.
- Latency: out_valid rises the clock after the CMD stop bit is sampled.
- frame_err and overrun are high for exactly one clock, in the cycle after the stop bit is sampled.
- Back-to-back packets: the start bit may immediately follow a stop bit with no idle gap.
- The CRC may be computed serially as bits arrive or combinationally at the CMD packet. The result must be available by the STOP cycle.

## Test plan
- Zero-operand command, DATA_W=32: 8 DATA packets of 0x00, then CMD 0x0B (op=000, crc=1011). Required: one record with out_err=000, out_a=0, out_b=0, out_op=000.
- Byte order and CRC error, DATA_W=32: B bytes 0A 0B 0C 0D, A bytes 01 02 03 04, then CMD 0x40. Required: out_b=0x0A0B0C0D, out_a=0x01020304, out_op=100, out_err=ERR_CRC.
- Frame count error: 7 DATA packets, then CMD 0x47 (ADD, crc 0111). Required: out_err=ERR_DATA. A following correct 8+1 sequence must yield out_err=000.
- Bad opcode and stop bit:
  - 8 zero DATA packets, then a CMD with op=111 and its correct CRC. Required: ERR_OP.
  - A DATA packet with stop bit 0. Required: frame_err pulses once and no record is produced.
- Backpressure: hold out_ready=0 across two complete valid commands. Required: the first record is held stable, overrun pulses once, and the second record is lost. Raise out_ready and the first record transfers.
- Width and reset:
  - DATA_W=8: 2 zero DATA packets, then CMD 0x47. Required: out_err=000.
  - Assert rst_n mid-PAYLOAD. Required: all outputs return to reset values asynchronously.
